// File: rtl/mem_pkg.sv
// mem_pkg: constants shared by the memory arbiter and its clients.
//   ADDR_W_DEF / DATA_W_DEF : default block address / block data widths
//   state_e                 : arbiter FSM state encoding
//   CL_I / CL_D             : client identifiers (I-cache / D-cache)
package mem_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam logic CL_I = 1'b0;
  localparam logic CL_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (I-cache / D-cache) block arbiter onto one shared
// memory port. One transaction in flight at a time; ties go round-robin.
//   clk, proc_reset            : clock, async active-high reset
//   i_mem_* / d_mem_*          : client request (read/write/addr/wdata) in,
//                                rdata/ready out (ready is a one-cycle pulse)
//   mem_read/write/addr/wdata  : registered memory request out
//   mem_rdata, mem_ready       : memory response in
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_r, rdata_d;
  logic                grant_r, grant_d;
  logic                last_grant_r, last_grant_d;
  logic                i_req, d_req, sel;

  always_comb begin
    i_req = i_mem_read | i_mem_write;
    d_req = d_mem_read | d_mem_write;
    // On a tie, favour whoever was not served last; otherwise the sole requester.
    if (i_req && d_req) sel = (last_grant_r == CL_I) ? CL_D : CL_I;
    else                sel = d_req ? CL_D : CL_I;

    state_d      = state_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_r;
    grant_d      = grant_r;
    last_grant_d = last_grant_r;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d      = S_ISSUE;
          grant_d      = sel;
          last_grant_d = sel;
          // Write takes priority if a client raises both lines.
          if (sel == CL_D) begin
            mem_write_d = d_mem_write;
            mem_read_d  = d_mem_read & ~d_mem_write;
            mem_addr_d  = d_mem_addr;
            mem_wdata_d = d_mem_wdata;
          end else begin
            mem_write_d = i_mem_write;
            mem_read_d  = i_mem_read & ~i_mem_write;
            mem_addr_d  = i_mem_addr;
            mem_wdata_d = i_mem_wdata;
          end
        end
      end
      S_ISSUE: begin
        // Client lines are deliberately not looked at here.
        if (mem_ready) begin
          if (mem_read_q) rdata_d = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_RESP;
        end
      end
      // Clients retarget their request during this cycle, so no sampling.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q      <= S_IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_r      <= '0;
      grant_r      <= CL_I;
      last_grant_r <= CL_D;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_r      <= rdata_d;
      grant_r      <= grant_d;
      last_grant_r <= last_grant_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_mem_rdata = rdata_r;
  assign d_mem_rdata = rdata_r;
  assign i_mem_ready = (state_q == S_RESP) && (grant_r == CL_I);
  assign d_mem_ready = (state_q == S_RESP) && (grant_r == CL_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks with a queue-based client/memory model.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata;
  logic          i_mem_ready, d_mem_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct { logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef struct { logic cl; logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } port_t;
  typedef struct { logic cl; logic [DW-1:0] rdata; int cyc; } resp_t;

  req_t          iq[$], dq[$];
  port_t         plog[$], expq[$];
  resp_t         rlog[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] model_rdata;
  int            errors = 0, checks = 0;
  int            cyc, both_rdy, timed_out;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_inputs();
    i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    clear_inputs();
    model_rdata = '0;
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Reference: with both clients continuously requesting from the start and
  // I winning the first tie, the port sees strict I/D alternation until one
  // side runs dry, then the remainder of the other side in order.
  task automatic build_expected();
    req_t ic[$], dc[$];
    logic turn;
    ic = iq; dc = dq; expq.delete(); turn = CL_I;
    while (ic.size() > 0 || dc.size() > 0) begin
      if (dc.size() == 0 || (ic.size() > 0 && turn == CL_I)) begin
        expq.push_back('{CL_I, ic[0].rd & ~ic[0].wr, ic[0].wr, ic[0].addr, ic[0].wdata, 0});
        void'(ic.pop_front()); turn = CL_D;
      end else begin
        expq.push_back('{CL_D, dc[0].rd & ~dc[0].wr, dc[0].wr, dc[0].addr, dc[0].wdata, 0});
        void'(dc.pop_front()); turn = CL_I;
      end
    end
  endtask

  // Cycle engine: clients hold their head request until served; memory
  // answers after 'lat' wait cycles (lat<0: random 0..3). Only observes.
  task automatic run_traffic(input int lat, input int i_dly, input int budget);
    bit busy;
    int wt;
    busy = 0; wt = 0; cyc = 0; both_rdy = 0; timed_out = 0;
    plog.delete(); rlog.delete(); exp_rd_q.delete();
    forever begin
      @(negedge clk);
      cyc++;
      if (i_mem_ready && d_mem_ready) both_rdy++;
      if (i_mem_ready) begin
        rlog.push_back('{CL_I, i_mem_rdata, cyc});
        if (iq.size() > 0) void'(iq.pop_front());
      end
      if (d_mem_ready) begin
        rlog.push_back('{CL_D, d_mem_rdata, cyc});
        if (dq.size() > 0) void'(dq.pop_front());
      end
      if (mem_ready) begin
        mem_ready = 0; busy = 0; mem_rdata = rnd128();
      end else begin
        mem_rdata = rnd128();
        if (!busy && (mem_read || mem_write)) begin
          busy = 1;
          wt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
          plog.push_back('{1'b0, mem_read, mem_write, mem_addr, mem_wdata, cyc});
        end
        if (busy) begin
          if (wt == 0) begin
            mem_ready = 1;
            if (mem_read) model_rdata = mem_rdata;
            exp_rd_q.push_back(model_rdata);
          end else wt--;
        end
      end
      i_mem_read  = (iq.size() > 0 && cyc >= i_dly) ? iq[0].rd : 1'b0;
      i_mem_write = (iq.size() > 0 && cyc >= i_dly) ? iq[0].wr : 1'b0;
      i_mem_addr  = (iq.size() > 0) ? iq[0].addr  : '0;
      i_mem_wdata = (iq.size() > 0) ? iq[0].wdata : '0;
      d_mem_read  = (dq.size() > 0) ? dq[0].rd : 1'b0;
      d_mem_write = (dq.size() > 0) ? dq[0].wr : 1'b0;
      d_mem_addr  = (dq.size() > 0) ? dq[0].addr  : '0;
      d_mem_wdata = (dq.size() > 0) ? dq[0].wdata : '0;
      if (iq.size() == 0 && dq.size() == 0 && !busy && !mem_ready) break;
      if (cyc >= budget) begin timed_out = 1; break; end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    clear_inputs();
    i_mem_read = 1; d_mem_write = 1;
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h rdy=%b%b, required all zero",
               mem_read, mem_write, mem_addr, i_mem_ready, d_mem_ready);
    end
    clear_inputs();
    proc_reset = 1'b0;
    model_rdata = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: rd=%b wr=%b irdy=%b drdy=%b, required 0", k,
                 mem_read, mem_write, i_mem_ready, d_mem_ready);
      end
    end
  endtask

  task automatic test_single_read();
    int irdy, drdy;
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    irdy = 0; drdy = 0;
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h0000010;
    @(negedge clk);
    checks++;
    if (mem_read !== 1 || mem_write !== 0 || mem_addr !== 28'h10) begin
      errors++;
      $display("FAIL single_issue: rd=%b wr=%b addr=%h, required 1 0 0000010", mem_read, mem_write, mem_addr);
    end
    // Client lines wiggle during the transaction; the port must not follow.
    i_mem_addr = 28'hFFF; i_mem_write = 1; d_mem_read = 1;
    repeat (2) begin
      @(negedge clk);
      if (d_mem_ready) drdy++;
      if (i_mem_ready) irdy++;
    end
    checks++;
    if (mem_read !== 1 || mem_write !== 0 || mem_addr !== 28'h10) begin
      errors++;
      $display("FAIL single_hold: rd=%b wr=%b addr=%h, required 1 0 0000010", mem_read, mem_write, mem_addr);
    end
    d_mem_read = 0; i_mem_write = 0; i_mem_addr = 28'h10;
    mem_ready = 1; mem_rdata = a5;
    @(negedge clk);
    mem_ready = 0; mem_rdata = rnd128(); i_mem_read = 0;
    checks++;
    if (i_mem_ready !== 1 || i_mem_rdata !== a5 || mem_read !== 0) begin
      errors++;
      $display("FAIL single_resp: irdy=%b rdata=%h rd=%b, required 1 %h 0", i_mem_ready, i_mem_rdata, mem_read, a5);
    end
    if (i_mem_ready) irdy++;
    if (d_mem_ready) drdy++;
    repeat (4) begin
      @(negedge clk);
      if (i_mem_ready) irdy++;
      if (d_mem_ready) drdy++;
    end
    checks++;
    if (irdy !== 1 || drdy !== 0) begin
      errors++;
      $display("FAIL single_ready_count: i=%0d d=%0d, required 1 0", irdy, drdy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    iq.delete(); dq.delete();
    iq.push_back('{1'b1, 1'b0, 28'h20, '0});
    dq.push_back('{1'b0, 1'b1, 28'h30, 128'h1234});
    run_traffic(1, 0, 200);
    checks++;
    if (timed_out != 0 || plog.size() != 2 || rlog.size() != 2) begin
      errors++;
      $display("FAIL simul_count: timeout=%0d port=%0d resp=%0d, required 0 2 2", timed_out, plog.size(), rlog.size());
    end else begin
      checks++;
      if (plog[0].rd !== 1 || plog[0].addr !== 28'h20 || rlog[0].cl !== CL_I) begin
        errors++;
        $display("FAIL simul_first: rd=%b addr=%h cl=%b, required 1 0000020 I", plog[0].rd, plog[0].addr, rlog[0].cl);
      end
      checks++;
      if (plog[1].wr !== 1 || plog[1].addr !== 28'h30 || plog[1].wdata !== 128'h1234 || rlog[1].cl !== CL_D) begin
        errors++;
        $display("FAIL simul_second: wr=%b addr=%h wdata=%h cl=%b, required 1 0000030 1234 D",
                 plog[1].wr, plog[1].addr, plog[1].wdata, rlog[1].cl);
      end
    end
  endtask

  task automatic test_wb_refill();
    logic [DW-1:0] wb;
    logic [AW-1:0] exp_addr [3];
    logic          exp_wr   [3];
    logic          exp_cl   [3];
    wb = rnd128();
    exp_addr = '{28'h50, 28'h60, 28'h50};
    exp_wr   = '{1'b1, 1'b0, 1'b0};
    exp_cl   = '{CL_D, CL_I, CL_D};
    do_reset();
    iq.delete(); dq.delete();
    dq.push_back('{1'b0, 1'b1, 28'h50, wb});
    dq.push_back('{1'b1, 1'b0, 28'h50, '0});
    iq.push_back('{1'b1, 1'b0, 28'h60, '0});
    run_traffic(2, 2, 300);
    checks++;
    if (timed_out != 0 || plog.size() != 3 || rlog.size() != 3 || both_rdy != 0) begin
      errors++;
      $display("FAIL wb_count: timeout=%0d port=%0d resp=%0d both=%0d, required 0 3 3 0",
               timed_out, plog.size(), rlog.size(), both_rdy);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (plog[k].addr !== exp_addr[k] || plog[k].wr !== exp_wr[k] || rlog[k].cl !== exp_cl[k] ||
            rlog[k].rdata !== exp_rd_q[k]) begin
          errors++;
          $display("FAIL wb_order[%0d]: addr=%h wr=%b cl=%b rdata=%h, required %h %b %b %h", k,
                   plog[k].addr, plog[k].wr, rlog[k].cl, rlog[k].rdata, exp_addr[k], exp_wr[k], exp_cl[k], exp_rd_q[k]);
        end
      end
      checks++;
      if (plog[0].wdata !== wb) begin
        errors++;
        $display("FAIL wb_wdata: %h, required %h", plog[0].wdata, wb);
      end
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    iq.delete(); dq.delete();
    for (int k = 0; k < 4; k++) iq.push_back('{1'b1, 1'b0, AW'(28'h80 + k), '0});
    run_traffic(0, 0, 200);
    checks++;
    if (timed_out != 0 || plog.size() != 4 || rlog.size() != 4) begin
      errors++;
      $display("FAIL zw_count: timeout=%0d port=%0d resp=%0d, required 0 4 4", timed_out, plog.size(), rlog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rlog[k].cyc - plog[k].cyc != 1 || rlog[k].rdata !== exp_rd_q[k] ||
            plog[k].addr !== AW'(28'h80 + k)) begin
          errors++;
          $display("FAIL zw_txn[%0d]: resp_lat=%0d rdata=%h addr=%h, required 1 %h %h", k,
                   rlog[k].cyc - plog[k].cyc, rlog[k].rdata, plog[k].addr, exp_rd_q[k], AW'(28'h80 + k));
        end
        if (k > 0) begin
          checks++;
          if (plog[k].cyc - plog[k-1].cyc != 3) begin
            errors++;
            $display("FAIL zw_spacing[%0d]: %0d cycles, required 3", k, plog[k].cyc - plog[k-1].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int ni, nd;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      iq.delete(); dq.delete();
      ni = $urandom_range(1, 6); nd = $urandom_range(1, 6);
      for (int k = 0; k < ni; k++) begin
        logic r, w;
        r = 1'($urandom); w = 1'($urandom); if (!r && !w) r = 1;
        iq.push_back('{r, w, AW'(28'h100 + k), rnd128()});
      end
      for (int k = 0; k < nd; k++) begin
        logic r, w;
        r = 1'($urandom); w = 1'($urandom); if (!r && !w) r = 1;
        dq.push_back('{r, w, AW'(28'h200 + k), rnd128()});
      end
      build_expected();
      run_traffic(-1, 0, 1000);
      checks++;
      if (timed_out != 0 || plog.size() != expq.size() || rlog.size() != expq.size() || both_rdy != 0) begin
        errors++;
        $display("FAIL rand%0d_count: timeout=%0d port=%0d resp=%0d both=%0d, required 0 %0d %0d 0",
                 it, timed_out, plog.size(), rlog.size(), both_rdy, expq.size(), expq.size());
      end else begin
        for (int k = 0; k < expq.size(); k++) begin
          checks++;
          if (plog[k].rd !== expq[k].rd || plog[k].wr !== expq[k].wr || plog[k].addr !== expq[k].addr ||
              (expq[k].wr && plog[k].wdata !== expq[k].wdata) || rlog[k].cl !== expq[k].cl ||
              rlog[k].rdata !== exp_rd_q[k]) begin
            errors++;
            $display("FAIL rand%0d_txn[%0d]: rd=%b wr=%b addr=%h cl=%b rdata=%h, required %b %b %h %b %h",
                     it, k, plog[k].rd, plog[k].wr, plog[k].addr, rlog[k].cl, rlog[k].rdata,
                     expq[k].rd, expq[k].wr, expq[k].addr, expq[k].cl, exp_rd_q[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rdy;
    rdy = 0;
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h70;
    @(negedge clk);
    checks++;
    if (mem_read !== 1) begin
      errors++;
      $display("FAIL mid_issue: rd=%b, required 1", mem_read);
    end
    #2 proc_reset = 1'b1;
    #1;
    checks++;
    if (mem_read !== 0 || mem_write !== 0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL mid_async: rd=%b wr=%b addr=%h, required 0 0 0", mem_read, mem_write, mem_addr);
    end
    mem_ready = 1; mem_rdata = rnd128(); i_mem_read = 0;
    repeat (2) begin
      @(negedge clk);
      if (i_mem_ready || d_mem_ready) rdy++;
    end
    mem_ready = 0; model_rdata = '0;
    proc_reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (i_mem_ready || d_mem_ready) rdy++;
    end
    checks++;
    if (rdy != 0) begin
      errors++;
      $display("FAIL mid_no_ready: %0d ready pulses, required 0", rdy);
    end
    iq.delete(); dq.delete();
    iq.push_back('{1'b1, 1'b0, 28'h40, '0});
    run_traffic(1, 0, 100);
    checks++;
    if (timed_out != 0 || plog.size() != 1 || rlog.size() != 1) begin
      errors++;
      $display("FAIL mid_recover_count: timeout=%0d port=%0d resp=%0d, required 0 1 1", timed_out, plog.size(), rlog.size());
    end else if (plog[0].addr !== 28'h40 || rlog[0].cl !== CL_I || rlog[0].rdata !== exp_rd_q[0]) begin
      errors++;
      $display("FAIL mid_recover: addr=%h cl=%b rdata=%h, required 0000040 I %h", plog[0].addr, rlog[0].cl,
               rlog[0].rdata, exp_rd_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_wb_refill();
    test_zero_wait();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
